music_note_rx: RTL



---
 rtl/music_proto_pkg.sv | 53 +++++
 rtl/music_note_rx_if.sv | 31 +++
 rtl/music_uart_rx.sv | 143 ++++++++++++++
 rtl/music_note_rx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/music_proto_pkg.sv
// Tile/note link protocol constants and helpers, shared by the receive and transmit sides.
package music_proto_pkg;

  localparam logic [7:0] TILE_BASE   = 8'h41;
  localparam logic [7:0] TILE_LAST   = 8'h50;
  localparam logic [7:0] DUR_HALF_CH = 8'h32;
  localparam logic [7:0] DUR_FULL_CH = 8'h34;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_SP       = 8'h20;

  localparam logic [2:0] DUR_HALF = 3'b010;
  localparam logic [2:0] DUR_FULL = 3'b100;

  localparam int NOTE_W        = 7;
  localparam int NOTE_TILE_MSB = 6;
  localparam int NOTE_TILE_LSB = 3;
  localparam int NOTE_DUR_MSB  = 2;
  localparam int NOTE_DUR_LSB  = 0;

  typedef logic [NOTE_W-1:0] note_t;

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } uart_state_e;

  typedef enum logic {
    P_TILE = 1'b0,
    P_DUR  = 1'b1
  } parse_state_e;

  function automatic logic is_tile_ch(input logic [7:0] b);
    return (b >= TILE_BASE) && (b <= TILE_LAST);
  endfunction

  function automatic logic is_blank_ch(input logic [7:0] b);
    return (b == CH_LF) || (b == CH_CR) || (b == CH_SP);
  endfunction

  function automatic logic [3:0] tile_of(input logic [7:0] b);
    logic [7:0] d;
    d = b - TILE_BASE;
    return d[3:0];
  endfunction

  function automatic note_t make_note(input logic [3:0] tile, input logic [2:0] dur);
    return {tile, dur};
  endfunction

endpackage

// File: rtl/music_note_rx_if.sv
// Serial-in / note-out bundle between the link receiver and the tile scheduler.
interface music_note_rx_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 7
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             rx;
  logic             clear;
  logic             note_ready;
  logic             note_valid;
  logic [3:0]       note_tile;
  logic [2:0]       note_dur;
  logic [LVL_W-1:0] fifo_level;
  logic [CNT_W-1:0] note_count;
  logic             frame_err;
  logic             sync_err;
  logic             overflow;

  modport master (
    output rx, clear, note_ready,
    input  note_valid, note_tile, note_dur, fifo_level, note_count,
           frame_err, sync_err, overflow
  );

  modport slave (
    input  rx, clear, note_ready,
    output note_valid, note_tile, note_dur, fifo_level, note_count,
           frame_err, sync_err, overflow
  );
endinterface

// File: rtl/music_uart_rx.sv
// 8N1 UART receive engine: two-flop synchroniser, start-bit glitch filter,
// mid-bit sampling and one-cycle byte / frame-error strobes.
module music_uart_rx
  import music_proto_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic          r_sync_1;
  logic          r_sync_2;
  logic          r_rx_d;
  logic          w_rx;
  uart_state_e   r_state;
  uart_state_e   w_state_n;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_n;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_n;
  logic [7:0]    r_byte;
  logic [7:0]    w_byte_n;
  logic          r_byte_valid;
  logic          w_byte_valid_n;
  logic          r_frame_err;
  logic          w_frame_err_n;

  assign w_rx         = r_sync_2;
  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;

  // Synchronise rx and keep the previous sample for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_1 <= 1'b1;
      r_sync_2 <= 1'b1;
      r_rx_d   <= 1'b1;
    end else begin
      r_sync_1 <= i_rx;
      r_sync_2 <= r_sync_1;
      r_rx_d   <= w_rx;
    end
  end

  // Bit-engine state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= U_IDLE;
      r_cnt        <= {CW{1'b0}};
      r_bit        <= 3'd0;
      r_shift      <= 8'h00;
      r_byte       <= 8'h00;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_bit        <= w_bit_n;
      r_shift      <= w_shift_n;
      r_byte       <= w_byte_n;
      r_byte_valid <= w_byte_valid_n;
      r_frame_err  <= w_frame_err_n;
    end
  end

  // Next-state and strobe generation
  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_bit_n        = r_bit;
    w_shift_n      = r_shift;
    w_byte_n       = r_byte;
    w_byte_valid_n = 1'b0;
    w_frame_err_n  = 1'b0;
    case (r_state)
      U_IDLE: begin
        if (r_rx_d && !w_rx) begin
          w_state_n = U_START;
          w_cnt_n   = {CW{1'b0}};
        end else begin
          w_state_n = U_IDLE;
        end
      end
      U_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_n = {CW{1'b0}};
          w_bit_n = 3'd0;
          if (!w_rx) begin
            w_state_n = U_DATA;
          end else begin
            w_state_n = U_IDLE;
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      U_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_n   = {CW{1'b0}};
          w_shift_n = {w_rx, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_n = U_STOP;
          end else begin
            w_bit_n = r_bit + 3'd1;
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      U_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_n   = {CW{1'b0}};
          w_state_n = U_IDLE;
          if (w_rx) begin
            w_byte_n       = r_shift;
            w_byte_valid_n = 1'b1;
          end else begin
            w_frame_err_n = 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_n = U_IDLE;
        w_cnt_n   = {CW{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/music_note_rx.sv
// Note-link receiver: UART bytes are parsed as tile/duration pairs and the rebuilt
// note words are queued in a first-word-fall-through FIFO for the tile scheduler.
module music_note_rx
  import music_proto_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 7
) (
  input  logic            clk,
  input  logic            rst,
  music_note_rx_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [7:0]       w_byte;
  logic             w_byte_valid;
  logic             w_frame_err;

  parse_state_e     r_pstate;
  parse_state_e     w_pstate_n;
  logic [3:0]       r_tile;
  logic [3:0]       w_tile_n;
  logic             r_push;
  logic             w_push_n;
  note_t            r_push_note;
  note_t            w_push_note_n;
  logic             r_sync_err;
  logic             w_sync_err_n;

  note_t            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             w_valid;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  note_t            w_head;

  music_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (bus.rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err)
  );

  // Parser registers; the push is presented to the FIFO one cycle after the byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pstate    <= P_TILE;
      r_tile      <= 4'd0;
      r_push      <= 1'b0;
      r_push_note <= {NOTE_W{1'b0}};
      r_sync_err  <= 1'b0;
    end else begin
      r_pstate    <= w_pstate_n;
      r_tile      <= w_tile_n;
      r_push      <= w_push_n;
      r_push_note <= w_push_note_n;
      r_sync_err  <= w_sync_err_n;
    end
  end

  // Record parser: tile letter then duration digit, with resync on a fresh letter
  always_comb begin
    w_pstate_n    = r_pstate;
    w_tile_n      = r_tile;
    w_push_n      = 1'b0;
    w_push_note_n = r_push_note;
    w_sync_err_n  = 1'b0;
    if (bus.clear) begin
      w_pstate_n = P_TILE;
    end else if (w_byte_valid) begin
      case (r_pstate)
        P_TILE: begin
          if (is_tile_ch(w_byte)) begin
            w_tile_n   = tile_of(w_byte);
            w_pstate_n = P_DUR;
          end else if (is_blank_ch(w_byte)) begin
            w_pstate_n = P_TILE;
          end else begin
            w_sync_err_n = 1'b1;
          end
        end
        P_DUR: begin
          if (w_byte == DUR_HALF_CH) begin
            w_push_n      = 1'b1;
            w_push_note_n = make_note(r_tile, DUR_HALF);
            w_pstate_n    = P_TILE;
          end else if (w_byte == DUR_FULL_CH) begin
            w_push_n      = 1'b1;
            w_push_note_n = make_note(r_tile, DUR_FULL);
            w_pstate_n    = P_TILE;
          end else if (is_tile_ch(w_byte)) begin
            w_sync_err_n = 1'b1;
            w_tile_n     = tile_of(w_byte);
            w_pstate_n   = P_DUR;
          end else begin
            w_sync_err_n = 1'b1;
            w_pstate_n   = P_TILE;
          end
        end
        default: w_pstate_n = P_TILE;
      endcase
    end else if (w_frame_err) begin
      w_pstate_n = P_TILE;
    end else begin
      w_pstate_n = r_pstate;
    end
  end

  assign w_valid   = (r_level != {LVL_W{1'b0}});
  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop     = w_valid && bus.note_ready;
  assign w_push_ok = r_push && (!w_full || w_pop);
  assign w_head    = r_mem[r_rd_ptr];

  // Note FIFO; a full FIFO still accepts a push when the head leaves in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= {NOTE_W{1'b0}};
      end
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_level    <= {LVL_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_level    <= {LVL_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= r_push_note;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_push_ok && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_W'(1);
      end
      r_overflow <= r_push && w_full && !w_pop;
    end
  end

  assign bus.note_valid = w_valid;
  assign bus.note_tile  = w_valid ? w_head[NOTE_TILE_MSB:NOTE_TILE_LSB] : 4'd0;
  assign bus.note_dur   = w_valid ? w_head[NOTE_DUR_MSB:NOTE_DUR_LSB] : 3'd0;
  assign bus.fifo_level = r_level;
  assign bus.note_count = r_count;
  assign bus.frame_err  = w_frame_err;
  assign bus.sync_err   = r_sync_err;
  assign bus.overflow   = r_overflow;

endmodule
